// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and widths for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {RESET_HOLD, WAIT_LOCK, STABLE, RUN, FAIL} state_t;

    localparam int RETRY_W   = 3;
    localparam int LOL_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with async active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset/lock handshake with timeout, retries and lock qualification.
// Define PLL_SEQ_LOL_STATS_EN to add the lol_cnt loss-of-lock counter output.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_SEQ_LOL_STATS_EN
   ,output logic [LOL_CNT_W-1:0] lol_cnt
`endif
);
    localparam int CNT_W = $clog2(max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [RETRY_W-1:0] retry_nx;
    logic               fail_nx;
    logic               locked_s;

    sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(pll_locked), .q(locked_s));

    always_comb begin
        state_nx = state;
        retry_nx = retry_cnt;
        fail_nx  = fail;
        case (state)
            RESET_HOLD: state_nx = (cnt == HOLD_LAST) ? WAIT_LOCK : RESET_HOLD;
            WAIT_LOCK:
                if (locked_s) begin
                    state_nx = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_cnt == RETRY_W'(MAX_RETRIES - 1)) begin
                        state_nx = FAIL;
                        retry_nx = RETRY_W'(MAX_RETRIES);
                        fail_nx  = 1'b1;
                    end else begin
                        state_nx = RESET_HOLD;
                        retry_nx = retry_cnt + RETRY_W'(1);
                    end
                end
            STABLE:
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nx = RUN;
                    retry_nx = '0;
                end
            RUN:     state_nx = locked_s ? RUN : RESET_HOLD;
            FAIL:    state_nx = FAIL;
            default: state_nx = RESET_HOLD;
        endcase
        // relock_req overrides any event decided above
        if (relock_req) begin
            state_nx = RESET_HOLD;
            retry_nx = '0;
            fail_nx  = 1'b0;
        end
        cnt_nx = (relock_req || state_nx != state) ? '0 : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= RESET_HOLD;
            cnt       <= '0;
            retry_cnt <= '0;
            fail      <= 1'b0;
            pll_rst   <= 1'b1;
            ready     <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            retry_cnt <= retry_nx;
            fail      <= fail_nx;
            pll_rst   <= (state_nx == RESET_HOLD) || (state_nx == FAIL);
            ready     <= (state_nx == RUN);
        end

`ifdef PLL_SEQ_LOL_STATS_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            lol_cnt <= '0;
        else if (state == RUN && !locked_s && !relock_req && lol_cnt != '1)
            lol_cnt <= lol_cnt + LOL_CNT_W'(1);
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: randomized scenario bench; predicted output-change events are queued and checked by a monitor.
module tb_pll_lock_sequencer;

    localparam int H = 16;
    localparam int T = 200;
    localparam int L = 64;
    localparam int M = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, ready, fail;
    logic [2:0] retry_cnt;
`ifdef PLL_SEQ_LOL_STATS_EN
    logic [7:0] lol_cnt;
`endif

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES(H), .LOCK_TIMEOUT_CYCLES(T),
        .LOCK_STABLE_CYCLES(L), .MAX_RETRIES(M)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .relock_req(relock_req),
        .pll_rst(pll_rst), .ready(ready), .fail(fail), .retry_cnt(retry_cnt)
`ifdef PLL_SEQ_LOL_STATS_EN
       ,.lol_cnt(lol_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic [5:0] v; } ev_t;
    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  lol_exp = 0;

    task automatic check(input string name, input int got, input int req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, got, req);
        end
    endtask

    // Expected change of {pll_rst, ready, fail, retry_cnt} visible after edge c
    task automatic push(input int c, input logic r, input logic rd, input logic f, input logic [2:0] rc);
        ev_t e;
        e.c = c;
        e.v = {r, rd, f, rc};
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int x);
        while (cyc < x) @(negedge clk);
    endtask

    logic [5:0] prev = 6'b100000;
    always @(negedge clk) begin
        logic [5:0] v;
        ev_t e;
        v = {pll_rst, ready, fail, retry_cnt};
        if (v !== prev) begin
            prev = v;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_change cyc=%0d got=%b required=no_change", cyc, v);
            end else begin
                e = exp_q.pop_front();
                check("event_value", int'(v), int'(e.v));
                check("event_cycle", cyc, e.c);
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_pll_rst", pll_rst, 1);
        check("rst_ready", ready, 0);
        check("rst_fail", fail, 0);
        check("rst_retry_cnt", retry_cnt, 0);
    endtask

    // Raise lock a random time after WAIT_LOCK entry at edge w; ready follows 3+L edges later
    task automatic lock_from(input int w);
        int c;
        wait_until(w + $urandom_range(2, T - 10));
        pll_locked = 1'b1;
        c = cyc;
        push(c + 3 + L, 0, 1, 0, 0);
        wait_until(c + 3 + L + 2);
    endtask

    task automatic drop_in_run(output int w);
        int c;
        wait_until(cyc + $urandom_range(5, 40));
        pll_locked = 1'b0;
        c = cyc;
        push(c + 3, 1, 0, 0, 0);
        w = c + 3 + H;
        push(w, 0, 0, 0, 0);
        lol_exp++;
    endtask

    task automatic glitch_lock(input int w);
        int c, g;
        wait_until(w + $urandom_range(2, T - 10));
        pll_locked = 1'b1;
        c = cyc;
        g = $urandom_range(5, L - 5);
        wait_until(c + g);
        pll_locked = 1'b0;
        wait_until(c + g + 10);
        pll_locked = 1'b1;
        push(c + g + 13 + L, 0, 1, 0, 0);
        wait_until(c + g + 13 + L + 2);
    endtask

    task automatic relock_at_completion(input int w);
        int c;
        wait_until(w + $urandom_range(2, T - 10));
        pll_locked = 1'b1;
        c = cyc;
        wait_until(c + 2 + L);
        relock_req = 1'b1;
        wait_until(c + 3 + L);
        relock_req = 1'b0;
        push(c + 3 + L, 1, 0, 0, 0);
        push(c + 3 + L + H, 0, 0, 0, 0);
        push(c + 4 + 2 * L + H, 0, 1, 0, 0);
        wait_until(c + 4 + 2 * L + H + 2);
    endtask

    task automatic exhaust(input int w0);
        int w, t;
        w = w0;
        for (int k = 1; k <= M; k++) begin
            t = w + T;
            if (k < M) begin
                push(t, 1, 0, 0, 3'(k));
                w = t + H;
                push(w, 0, 0, 0, 3'(k));
            end else begin
                push(t, 1, 0, 1, 3'(M));
            end
        end
        wait_until(t + 5);
    endtask

    initial begin
        int r, c, w;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        r = cyc;
        push(r + H, 0, 0, 0, 0);
        lock_from(r + H);
        for (int k = 0; k < 3; k++) begin
            drop_in_run(w);
            lock_from(w);
        end
        drop_in_run(w);
        glitch_lock(w);
        drop_in_run(w);
        relock_at_completion(w);
        drop_in_run(w);
        exhaust(w);
        wait_until(cyc + $urandom_range(5, 30));
        relock_req = 1'b1;
        c = cyc;
        push(c + 1, 1, 0, 0, 0);
        push(c + 1 + H, 0, 0, 0, 0);
        @(negedge clk);
        relock_req = 1'b0;
        w = c + 1 + H;
        push(w + T, 1, 0, 0, 1);
        w = w + T + H;
        push(w, 0, 0, 0, 1);
        push(w + T, 1, 0, 0, 2);
        w = w + T + H;
        push(w, 0, 0, 0, 2);
        wait_until(w + T / 2);
`ifdef PLL_SEQ_LOL_STATS_EN
        check("lol_cnt", lol_cnt, lol_exp);
`endif
        push(cyc + 1, 1, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        lol_exp = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        push(r + H, 0, 0, 0, 0);
        lock_from(r + H);
        repeat (10) @(negedge clk);
        check("events_drained", exp_q.size(), 0);
`ifdef PLL_SEQ_LOL_STATS_EN
        check("lol_cnt_after_reset", lol_cnt, lol_exp);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
